// File: rtl/serial_out_scheduler_if.sv
// Handshake and shift-register drive bundle for serial_out_scheduler.
// master: the producer/shift-register side; slave: the scheduler.
interface serial_out_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_in;
    logic [NUM_REQ*WIDTH-1:0] data_in;
    logic [NUM_REQ-1:0]       ack_out;
    logic [ID_W-1:0]          grant_id_out;
    logic                     sr_start_out;
    logic [WIDTH-1:0]         sr_vect_out;
    logic                     frame_out;
    logic                     busy_out;
    logic                     done_out;

    modport master (
        output req_in, data_in,
        input  ack_out, grant_id_out, sr_start_out, sr_vect_out, frame_out, busy_out, done_out
    );

    modport slave (
        input  req_in, data_in,
        output ack_out, grant_id_out, sr_start_out, sr_vect_out, frame_out, busy_out, done_out
    );
endinterface

// File: rtl/serial_out_scheduler.sv
// Round-robin scheduler sharing one parallel-load serial-out shift register
// among NUM_REQ producers. One frame = IDLE sample, LOAD, WIDTH shifts, DONE.
module serial_out_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
) (
    input logic                    clk_in,
    input logic                    rst_in,
    serial_out_scheduler_if.slave  bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_t;

    state_t               state_q;
    logic [ID_W-1:0]      last_grant_q;
    logic [CNT_W-1:0]     shift_cnt_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [ID_W-1:0]      grant_id_q;
    logic                 sr_start_q;
    logic [WIDTH-1:0]     sr_vect_q;
    logic                 frame_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 found;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      cand;

    // Round-robin search starting just after the last grant, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((32'(last_grant_q) + 32'd1 + i) % NUM_REQ);
            if (!found && bus.req_in[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Frame FSM; every output is a register so the shifter sees clean edges.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            shift_cnt_q  <= '0;
            ack_q        <= '0;
            grant_id_q   <= '0;
            sr_start_q   <= 1'b0;
            sr_vect_q    <= '0;
            frame_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            ack_q      <= '0;
            sr_start_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q      <= StLoad;
                        sr_vect_q    <= bus.data_in[32'(winner) * WIDTH +: WIDTH];
                        grant_id_q   <= winner;
                        last_grant_q <= winner;
                        ack_q        <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << winner;
                        sr_start_q   <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                StLoad: begin
                    state_q     <= StShift;
                    shift_cnt_q <= '0;
                    frame_q     <= 1'b1;
                end
                StShift: begin
                    if (shift_cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= StDone;
                        frame_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        shift_cnt_q <= shift_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ack_out      = ack_q;
    assign bus.grant_id_out = grant_id_q;
    assign bus.sr_start_out = sr_start_q;
    assign bus.sr_vect_out  = sr_vect_q;
    assign bus.frame_out    = frame_q;
    assign bus.busy_out     = busy_q;
    assign bus.done_out     = done_q;
endmodule
